// File: rtl/seq_bw_multiplier_pkg.sv
// Shared definitions for the iterative Baugh-Wooley multiplier:
// FSM state encoding and the signed-mode accumulator seed constant.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Correction constant for modified Baugh-Wooley: 2^(aw-1) + 2^(bw-1) + 2^(aw+bw-1).
  // The caller truncates to aw+bw bits, which gives the reduction modulo 2^(aw+bw).
  function automatic logic [63:0] calc_k(input int aw, input int bw);
    return (64'd1 << (aw - 1)) + (64'd1 << (bw - 1)) + (64'd1 << (aw + bw - 1));
  endfunction

endpackage

// File: rtl/seq_bw_multiplier_if.sv
// Start/busy/done handshake plus operand and product bus for seq_bw_multiplier.
interface seq_bw_multiplier_if #(
  parameter int AW = 5,
  parameter int BW = 4
);
  logic              start;
  logic              signed_mode;
  logic [AW-1:0]     a;
  logic [BW-1:0]     b;
  logic              busy;
  logic              done;
  logic [AW+BW-1:0]  p;

  modport master (output start, signed_mode, a, b, input busy, done, p);
  modport slave  (input start, signed_mode, a, b, output busy, done, p);
endinterface

// File: rtl/seq_bw_multiplier_bw_pp_row.sv
// One partial-product row. In signed mode the MSB of ordinary rows and the
// low bits of the last row are inverted (modified Baugh-Wooley).
module bw_pp_row #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_a,
  input  logic          i_b_bit,
  input  logic          i_signed_mode,
  input  logic          i_is_last,
  output logic [AW-1:0] o_row
);

  logic [AW-1:0] w_and;

  assign w_and = i_a & {AW{i_b_bit}};

  // Select the row form for the current mode and row position.
  always_comb begin
    o_row = w_and;
    if (i_signed_mode) begin
      if (i_is_last) begin
        o_row = {w_and[AW-1], ~w_and[AW-2:0]};
      end else begin
        o_row = {~w_and[AW-1], w_and[AW-2:0]};
      end
    end
  end

endmodule

// File: rtl/seq_bw_multiplier.sv
// Iterative AW x BW multiplier, one partial-product row per clock,
// unsigned or signed (modified Baugh-Wooley) selected per operation.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding row r_cnt into the accumulator, BW cycles
// DONE  | done pulse, p valid; start here chains the next operation
module seq_bw_multiplier
  import seq_mul_pkg::*;
#(
  parameter int AW = 5,
  parameter int BW = 4
) (
  input logic          clk,
  input logic          rst,
  seq_bw_multiplier_if.slave bus
);

  localparam int PW = AW + BW;
  localparam int CW = $clog2(BW);
  localparam logic [PW-1:0] K = PW'(calc_k(AW, BW));

  state_t          r_state;
  logic [AW-1:0]   r_a;
  logic [BW-1:0]   r_b;
  logic            r_smode;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_p;
  logic            r_busy;
  logic            r_done;

  logic            w_is_last;
  logic [AW-1:0]   w_row;
  logic [PW-1:0]   w_sum;
  logic            w_accept;

  assign w_is_last = (r_cnt == CW'(BW - 1));
  assign w_accept  = bus.start && (r_state == IDLE || r_state == DONE);

  bw_pp_row #(.AW(AW)) u_row (
    .i_a           (r_a),
    .i_b_bit       (r_b[r_cnt]),
    .i_signed_mode (r_smode),
    .i_is_last     (w_is_last),
    .o_row         (w_row)
  );

  assign w_sum = r_acc + (PW'(w_row) << r_cnt);

  // Control FSM with operand capture, accumulation and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_smode <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_smode <= bus.signed_mode;
            r_cnt   <= '0;
            r_acc   <= bus.signed_mode ? K : '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
          if (w_is_last) begin
            r_p     <= w_sum;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.p    = r_p;

endmodule
